axis_tx_frame_arbiter: RTL
==========================

Name: axis_tx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one byte-wide AXI4-Stream GMII frame transmitter between N upstream frame sources (DMA and loopback/test generators).
- It grants one source, forwards that source's frame unmodified until the accepted tlast beat, then re-arbitrates.
- It sits directly in front of the transmitter input. It never splits or interleaves frames.

Parameters:
- N_PORTS, 4, number of requesting sources (2..8)
- STALL_LIMIT, 16, consecutive mid-frame stall cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  N_PORTS*8  packed source data; port i occupies bits [8i+7:8i]
- s_axis_tvalid  in  N_PORTS  per-source valid
- s_axis_tready  out  N_PORTS  per-source ready
- s_axis_tlast  in  N_PORTS  per-source end of frame
- s_axis_tuser  in  N_PORTS  per-source bad-frame flag
- m_axis_tdata  out  8  to the transmitter
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1
- cfg_port_en  in  N_PORTS  per-port eligibility mask
- grant  out  N_PORTS  one-hot current grant; all zero when idle
- busy  out  1  a frame is in progress
- frame_done  out  1  one-cycle pulse on each accepted output tlast beat

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, grant=0, last-grant pointer=N_PORTS-1
  - all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0
  - busy=0, frame_done=0
- IDLE:
  - A port is a requester when s_axis_tvalid[i] & cfg_port_en[i].
  - Round-robin search starts at last-grant+1 and wraps modulo N_PORTS.
  - The winner is registered into grant; state moves to BUSY on the next edge.
  - Arbitration latency is 1 cycle from request to first m_axis_tvalid.
  - With no requesters, the arbiter stays in IDLE.
- BUSY:
  - Combinational pass-through from the granted port: m_axis_tdata/tvalid/tlast/tuser follow the granted source, and s_axis_tready[g]=m_axis_tready.
  - All other s_axis_tready are 0.
  - busy=1.
- On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast:
  - frame_done pulses.
  - last-grant pointer is set to g; grant clears; state returns to IDLE.
  - Result: at least one idle cycle between frames. The transmitter IFG dominates anyway.
- The grant is held for the whole frame regardless of:
  - cfg_port_en changes mid-frame (the change affects the next arbitration only)
  - tvalid gaps from the granted source (without the optional feature)
- Single requester: it wins every arbitration; back-to-back frames are separated by one IDLE cycle.
- Simultaneous requests: the strict rotation order from last-grant+1 decides.
- A port that is disabled while requesting is skipped and is never granted.
- Reset mid-frame: all outputs drop immediately to their reset values. The partially forwarded frame is abandoned; the transmitter's own rst handles its side.

Optional Feature:
- Macro: TX_ARB_STALL_ABORT_EN.
- With the macro defined:
  - A 16-bit stall counter counts consecutive BUSY cycles in which s_axis_tvalid[g]=0. It clears on any source-valid cycle.
  - When the count reaches STALL_LIMIT, the state moves to ABORT.
- ABORT:
  - Drives m_axis_tvalid=1, m_axis_tdata=0, m_axis_tlast=1, m_axis_tuser=1, and holds them until m_axis_tready.
  - The transmitter then terminates the frame with tx_er; frame_done pulses.
  - Next state is DRAIN.
- DRAIN:
  - s_axis_tready[g]=1 and m_axis_tvalid=0.
  - The source's remaining beats are discarded through its tlast beat.
  - Then last-grant=g and the state returns to IDLE.
- Without the macro:
  - No counter, ABORT or DRAIN logic exists.
  - Stalls pass through unchanged, and the transmitter fails the frame itself.

Decomposition:
- Shared package axis_tx_arb_pkg holds:
  - the state encoding (IDLE, BUSY, ABORT, DRAIN)
  - the default STALL_LIMIT constant
  - a function onehot_to_index
- One sub-module: rr_pick, purely combinational.
  - Inputs: request vector and last-grant index.
  - Output: one-hot winner and its index.
  - Reusable by other arbiters in the codebase.

Test Plan (N_PORTS=4):
1. Ports 0 and 2 each request a 10-byte frame at the same time, last-grant=3 → port 0's frame is forwarded completely, then port 2's. Two frame_done pulses; no interleaved bytes.
2. All 4 ports continuously offer 3-byte frames → grant sequence 0,1,2,3,0. Each frame is contiguous, and each tlast is followed by exactly one IDLE cycle.
3. cfg_port_en=4'b1011 with all ports requesting → port 2 is never granted; its s_axis_tready stays 0.
4. m_axis_tready toggles 1,0,1,0 during port 1's 8-byte frame → all 8 bytes arrive in order and the grant holds until tlast.
5. rst_n is asserted on byte 5 of a 10-byte frame → on the same cycle, grant=0, m_axis_tvalid=0 and all s_axis_tready=0. After release, fresh arbitration starts from port 0.
6. (TX_ARB_STALL_ABORT_EN, STALL_LIMIT=16) Source 3 deasserts tvalid for 20 cycles after byte 4 → an abort beat appears after 16 stall cycles with tdata=0, tlast=1, tuser=1. The source's remaining bytes through its tlast are drained with no output, then the arbiter returns to IDLE.

Source files
------------

// File: rtl/axis_tx_arb_pkg.sv
// Shared definitions for the TX frame arbiter: FSM state encoding,
// default stall limit, and a one-hot to index helper.
package axis_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int STALL_LIMIT_DEFAULT = 16;
  localparam int STALL_CNT_W         = 16;

  // Index of the set bit in a one-hot vector of up to 8 bits (0 when empty).
  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_tx_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting
// one position after last_idx_i and wrapping, returns the first requester.
module rr_pick
  import axis_tx_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_idx_i,
  output logic [N-1:0]    winner_oh_o,
  output logic [IDXW-1:0] winner_idx_o,
  output logic            valid_o
);

  logic [IDXW-1:0] cand;
  logic            found;

  // Walk the rotation order last+1 .. last+N and keep the first hit.
  always_comb begin
    winner_oh_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDXW'((int'(last_idx_i) + k) % N);
      if (!found && req_i[cand]) begin
        winner_oh_o[cand] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  assign valid_o      = found;
  assign winner_idx_o = IDXW'(onehot_to_index(8'(winner_oh_o)));

endmodule

// File: rtl/axis_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a byte-wide AXI4-Stream
// GMII transmitter. A grant is held from the first beat through the
// accepted tlast beat; re-arbitration happens in a single IDLE cycle.
// Optional mid-frame stall abort is compiled in with TX_ARB_STALL_ABORT_EN.
module axis_tx_frame_arbiter
  import axis_tx_arb_pkg::*;
#(
  parameter int N_PORTS     = 4,
  parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_PORTS*8-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]   s_axis_tvalid,
  output logic [N_PORTS-1:0]   s_axis_tready,
  input  logic [N_PORTS-1:0]   s_axis_tlast,
  input  logic [N_PORTS-1:0]   s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [N_PORTS-1:0]   cfg_port_en,
  output logic [N_PORTS-1:0]   grant,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int              IDXW     = $clog2(N_PORTS);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_PORTS - 1);

  if (N_PORTS < 2 || N_PORTS > 8) begin : g_bad_n_ports
    $error("axis_tx_frame_arbiter: N_PORTS must be 2..8");
  end
  if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_bad_stall_limit
    $error("axis_tx_frame_arbiter: STALL_LIMIT must be 1..65535");
  end

  arb_state_e          state_q, state_d;
  logic [N_PORTS-1:0]  grant_q, grant_d;
  logic [IDXW-1:0]     gidx_q, gidx_d;
  logic [IDXW-1:0]     last_q, last_d;

  logic [N_PORTS-1:0]  req;
  logic [N_PORTS-1:0]  pick_oh;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_valid;

`ifdef TX_ARB_STALL_ABORT_EN
  localparam logic [STALL_CNT_W-1:0] STALL_LIMIT_C = STALL_CNT_W'(STALL_LIMIT);
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
`endif

  // A disabled port never competes, even while it holds tvalid high.
  assign req   = s_axis_tvalid & cfg_port_en;
  assign grant = grant_q;

  rr_pick #(
    .N (N_PORTS)
  ) u_rr_pick (
    .req_i        (req),
    .last_idx_i   (last_q),
    .winner_oh_o  (pick_oh),
    .winner_idx_o (pick_idx),
    .valid_o      (pick_valid)
  );

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

`ifdef TX_ARB_STALL_ABORT_EN
  // Consecutive mid-frame cycles without source data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
`endif

  // Next-state logic and the combinational pass-through datapath.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    last_d        = last_q;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    busy          = 1'b0;
    frame_done    = 1'b0;
`ifdef TX_ARB_STALL_ABORT_EN
    stall_d       = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        busy                  = 1'b1;
        m_axis_tdata          = s_axis_tdata[{gidx_q, 3'b000} +: 8];
        m_axis_tvalid         = s_axis_tvalid[gidx_q];
        m_axis_tlast          = s_axis_tlast[gidx_q];
        m_axis_tuser          = s_axis_tuser[gidx_q];
        s_axis_tready[gidx_q] = m_axis_tready;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          frame_done = 1'b1;
          last_d     = gidx_q;
          grant_d    = '0;
          state_d    = ST_IDLE;
        end
`ifdef TX_ARB_STALL_ABORT_EN
        else if (!s_axis_tvalid[gidx_q]) begin
          if (stall_q + 1'b1 >= STALL_LIMIT_C) begin
            state_d = ST_ABORT;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end

`ifdef TX_ARB_STALL_ABORT_EN
      // Synthetic bad-frame terminator so the transmitter ends with tx_er.
      ST_ABORT: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
        if (m_axis_tready) begin
          frame_done = 1'b1;
          state_d    = ST_DRAIN;
        end
      end

      // Swallow the rest of the abandoned frame, nothing reaches the output.
      ST_DRAIN: begin
        busy                  = 1'b1;
        s_axis_tready[gidx_q] = 1'b1;
        if (s_axis_tvalid[gidx_q] && s_axis_tlast[gidx_q]) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
